// File: rtl/rgmii_ddr_rx.sv
// RGMII receive: dual-edge capture, byte realignment, DV/ER decode, and a preamble/SFD
// framer that streams frame bytes out with one byte of look-ahead so tlast needs no bubble.
module rgmii_ddr_rx #(
    parameter     TARGET      = "GENERIC",
    parameter     IODDR_STYLE = "IODDR2",
    parameter int MAX_LEN     = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rgmii_rxd,
    input  logic       rgmii_rx_ctl,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_frame,
    output logic       stat_rx_error,
    output logic       stat_bad_preamble
);

    localparam bit TARGET_OK = (TARGET == "SIM") || (TARGET == "GENERIC") ||
                               (TARGET == "XILINX") || (TARGET == "ALTERA");
    localparam bit STYLE_OK  = (IODDR_STYLE == "IODDR") || (IODDR_STYLE == "IODDR2");
    localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

    // Every target shares one fabric capture path so latency is identical across targets.
    generate
        if (!TARGET_OK || !STYLE_OK || (MAX_LEN < 1) || (MAX_LEN > 65534)) begin : g_bad_param
            $error("rgmii_ddr_rx: unsupported parameter value");
        end
    endgenerate

    logic [3:0] rise_d_q, fall_d_q;
    logic       rise_ctl_q, fall_ctl_q;
    logic [7:0] rx_byte_q;
    logic       dv_q, er_q;
    logic       vld0_q, vld1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_d_q   <= '0;
            rise_ctl_q <= 1'b0;
        end else begin
            rise_d_q   <= rgmii_rxd;
            rise_ctl_q <= rgmii_rx_ctl;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fall_d_q   <= '0;
            fall_ctl_q <= 1'b0;
        end else begin
            fall_d_q   <= rgmii_rxd;
            fall_ctl_q <= rgmii_rx_ctl;
        end
    end

    // vld1_q marks the first realigned byte built from real pin samples, so the reset
    // value of dv_q is never mistaken for an observed dv=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte_q <= '0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
        end else begin
            rx_byte_q <= {fall_d_q, rise_d_q};
            dv_q      <= rise_ctl_q;
            er_q      <= rise_ctl_q ^ fall_ctl_q;
            vld0_q    <= 1'b1;
            vld1_q    <= vld0_q;
        end
    end

    typedef enum logic [1:0] {S_DROP, S_IDLE, S_PREAMBLE, S_DATA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] len_q, len_d;
    logic        err_seen_q, err_seen_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        frame_q, frame_d;
    logic        rx_err_q, rx_err_d;
    logic        bad_pre_q, bad_pre_d;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        len_d        = len_q;
        err_seen_d   = err_seen_q;
        pre_cnt_d    = pre_cnt_q;
        tdata_d      = tdata_q;
        tvalid_d     = 1'b0;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_d      = 1'b0;
        rx_err_d     = 1'b0;
        bad_pre_d    = 1'b0;
        case (state_q)
            S_DROP: begin
                if (vld1_q && !dv_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (dv_q) begin
                    if (rx_byte_q == 8'h55) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d   = S_DROP;
                        bad_pre_d = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!dv_q) begin
                    state_d   = S_IDLE;
                    bad_pre_d = 1'b1;
                end else if (rx_byte_q == 8'h55) begin
                    if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (rx_byte_q == 8'hD5) begin
                    state_d      = S_DATA;
                    len_d        = '0;
                    err_seen_d   = 1'b0;
                    hold_valid_d = 1'b0;
                end else begin
                    state_d   = S_DROP;
                    bad_pre_d = 1'b1;
                end
            end
            S_DATA: begin
                if (dv_q) begin
                    if (hold_valid_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_q;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                    end
                    hold_d       = rx_byte_q;
                    hold_valid_d = 1'b1;
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                    if (er_q) begin
                        err_seen_d = 1'b1;
                        rx_err_d   = !err_seen_q;
                    end
                end else if (hold_valid_q) begin
                    tvalid_d     = 1'b1;
                    tdata_d      = hold_q;
                    tlast_d      = 1'b1;
                    tuser_d      = err_seen_q || (len_q > LEN_LIMIT);
                    frame_d      = 1'b1;
                    hold_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    bad_pre_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_DROP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_DROP;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            len_q        <= '0;
            err_seen_q   <= 1'b0;
            pre_cnt_q    <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_q      <= 1'b0;
            rx_err_q     <= 1'b0;
            bad_pre_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            len_q        <= len_d;
            err_seen_q   <= err_seen_d;
            pre_cnt_q    <= pre_cnt_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_q      <= frame_d;
            rx_err_q     <= rx_err_d;
            bad_pre_q    <= bad_pre_d;
        end
    end

    assign m_axis_tdata      = tdata_q;
    assign m_axis_tvalid     = tvalid_q;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tuser      = tuser_q;
    assign stat_frame        = frame_q;
    assign stat_rx_error     = rx_err_q;
    assign stat_bad_preamble = bad_pre_q;

endmodule

// File: doc/rgmii_ddr_rx.md
# rgmii_ddr_rx

Receive-side companion to the team's generic output-DDR path. It captures a 4-bit RGMII-style DDR data bus and control line on both clock edges, realigns them to one byte per rising edge, and decodes DV/ER. It strips preamble and SFD and delivers frame bytes as a non-backpressurable AXI-stream with tlast and an error flag. It sits between the PHY pins and the MAC receive datapath, in the same clock domain as the received clock.

## Interface
- TARGET, "GENERIC", capture primitive selection ("SIM", "GENERIC", "XILINX", "ALTERA"); every target has identical cycle behaviour and latency, padded with registers where needed.
- IODDR_STYLE, "IODDR2", vendor primitive style when TARGET="XILINX" ("IODDR", "IODDR2").
- MAX_LEN, 1518, maximum post-SFD byte count accepted without error; range 1..65534.
- clk  input  1  receive clock; rising and falling edges both sample pins.
- rst  input  1  asynchronous, active-high reset.
- rgmii_rxd  input  4  DDR data: rising edge carries bits 3:0, falling edge carries bits 7:4.
- rgmii_rx_ctl  input  1  DDR control: rising edge carries DV, falling edge carries DV XOR ER.
- m_axis_tdata  output  8  frame byte.
- m_axis_tvalid  output  1  beat valid; there is no tready and the sink must always accept.
- m_axis_tlast  output  1  last byte of frame.
- m_axis_tuser  output  1  frame error; meaningful only with tlast.
- stat_frame  output  1  one-cycle pulse per delivered frame (same cycle as tlast).
- stat_rx_error  output  1  one-cycle pulse, at most once per frame, on the first ER inside DATA.
- stat_bad_preamble  output  1  one-cycle pulse when a frame is discarded before SFD, or ends right after SFD.

## Operation
- Capture stage:
  - posedge samples rise nibble and rise ctl; negedge samples fall nibble and fall ctl.
  - The next posedge registers byte = {fall, rise}, dv = rise_ctl, er = rise_ctl ^ fall_ctl.
- Framer states:
  - DROP (reset state): ignore everything; go to IDLE on a cycle with dv=0.
  - IDLE: dv=0 stays in IDLE. dv=1 with byte 0x55 goes to PREAMBLE with pre_cnt=1. dv=1 with any other byte goes to DROP and pulses stat_bad_preamble.
  - PREAMBLE:
    - dv=1 with 0x55: stay; pre_cnt saturates at 7.
    - dv=1 with 0xD5: go to DATA and clear len, err_seen and hold_valid.
    - dv=1 with any other byte: go to DROP and pulse stat_bad_preamble.
    - dv=0: go to IDLE and pulse stat_bad_preamble.
  - DATA:
    - dv=1: if hold_valid, emit hold as a beat with tlast=0. In all cases load hold from byte, set hold_valid, and increment len (16-bit, saturating).
    - dv=0 with hold_valid: emit hold with tlast=1 and tuser=err_seen|(len>MAX_LEN), pulse stat_frame, go to IDLE.
    - dv=0 without hold_valid: pulse stat_bad_preamble, go to IDLE.
- ER handling:
  - er=1 in DATA sets err_seen; stat_rx_error pulses only on the cycle err_seen goes 0→1.
  - er is ignored in DROP, IDLE and PREAMBLE (false carrier and carrier extend).
- Byte checks inspect the byte only when dv=1.

## Timing
- Reset values: all outputs 0; state DROP; hold_valid=0; len=0; err_seen=0; capture registers 0.
- rst is asynchronous; deassertion is synchronous to clk in the parent.
- Reset mid-frame abandons the frame with no tlast. The block re-arms only after dv is seen low, so no fragment is ever emitted.
- Latency: a byte whose rise nibble is sampled at posedge N appears on m_axis at the cycle after posedge N+3. This is constant for all beats, including tlast.
- The tlast beat follows the final data beat by exactly one cycle: one-byte look-ahead, no bubble.
- Minimum inter-frame gap: one dv=0 cycle. That cycle both terminates the previous frame and is the IDLE cycle for the next.
- Simultaneous events:
  - ER on the same byte that exceeds MAX_LEN sets tuser; stat_rx_error still pulses once.
  - ER on the dv-falling cycle is not a DATA byte and is ignored.
- All outputs are registered. tdata, tlast and tuser hold their last values when tvalid=0.

## Test plan
- Reset with dv=1 and 0x55 bytes streaming: no beats or pulses. After dv goes low for 1 cycle, the next frame is accepted.
- Frame of 7×0x55, 0xD5, then payload 0x01..0x40:
  - 64 beats, tdata 0x01..0x40 consecutive.
  - tlast on 0x40 with tuser=0; stat_frame pulses once.
  - First beat 3 cycles after the 0x01 rise sample.
- Same frame with ER on payload byte 0x0A: 64 beats, tuser=1 at tlast, exactly one stat_rx_error pulse.
- Preamble 0x55,0x55,0xAA,... for 20 bytes: zero beats, one stat_bad_preamble pulse, no stat_frame.
- MAX_LEN=64 with 65-byte payload: 65 beats, tuser=1 at tlast. MAX_LEN=64 with 64-byte payload: tuser=0.
- Two frames separated by one dv=0 cycle, plus rst asserted mid-payload of a third frame: first two delivered intact, third produces no beats or tlast.
